burst_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream consumer among `N` requesters using valid/ready handshakes. Each requester sends a payload of parameterised type `T`. Requesters may hold the grant across a multi-beat burst, up to a bounded length. The block sits in front of any single-instance resource that several parameterised instances need to reach, such as a shared register port or a memory write port. Its purpose is to make type-parameter and value-parameter elaboration exercise real sequential logic.

---
 rtl/burst_rr_arbiter_pkg.sv | 7 +
 rtl/burst_rr_arbiter_if.sv | 21 ++
 rtl/burst_rr_arbiter_pick.sv | 29 ++
 rtl/burst_rr_arbiter.sv | 46 ++++
 tb/tb_burst_rr_arbiter.sv | 119 +++++++++++
 5 files changed

// File: rtl/burst_rr_arbiter_pkg.sv
// arb_pkg: shared FSM state type and wrapping pointer increment for burst_rr_arbiter
package arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_e;
  function automatic int rr_next(int ptr, int n);
    return ptr == n - 1 ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/burst_rr_arbiter_if.sv
// burst_rr_arbiter_if: requester and consumer valid/ready bundle around the arbiter
// master = requester/consumer side, slave = arbiter side
interface burst_rr_arbiter_if #(
  parameter type T = logic [31:0],
  parameter int N = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0] req_valid, req_last, req_ready;
  T req_data [N];
  logic out_valid, out_last, out_ready;
  T out_data;
  logic [IW-1:0] out_id;
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input req_ready, out_valid, out_data, out_last, out_id
  );
  modport slave (
    input req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/burst_rr_arbiter_pick.sv
// rr_pick: combinational rotate-priority encoder, first valid at or after ptr (wrapping)
// ports: valid (per-requester), ptr (start index) -> found (any valid), idx (winner)
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] hi, lo;
  logic hi_found;
  always_comb begin
    hi = '0;
    lo = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i]) lo = IW'(i);
      if (valid[i] && i >= int'(ptr)) begin
        hi = IW'(i);
        hi_found = 1'b1;
      end
    end
  end
  // nothing at or above ptr means the search wraps to the lowest valid index
  assign found = |valid;
  assign idx = hi_found ? hi : lo;
endmodule

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: round-robin arbiter with bounded burst lock in front of one shared consumer
// ports: clk, rst_n (async active-low), bus (slave: req_* from requesters, out_* to consumer)
module burst_rr_arbiter
  import arb_pkg::*;
#(
  parameter type T = logic [31:0],
  parameter int N = 4,
  parameter int MAX_BURST = 8,
  parameter int IW = $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  burst_rr_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_e state;
  logic [IW-1:0] ptr, owner, win, sel;
  logic [BW-1:0] beats;
  logic found, sel_valid, eff_last, fire;
  rr_pick #(.N(N)) u_pick (.valid(bus.req_valid), .ptr(ptr), .found(found), .idx(win));
  // outputs are gated by rst_n so an asserted reset silences the port before any clock edge
  always_comb begin
    sel = state == BURST ? owner : found ? win : ptr;
    sel_valid = rst_n && (state == BURST ? bus.req_valid[sel] : found);
    eff_last = bus.req_last[sel] || beats == BW'(MAX_BURST - 1);
    fire = sel_valid && bus.out_ready;
    bus.out_valid = sel_valid;
    bus.out_data = sel_valid ? T'(bus.req_data[sel]) : T'('0);
    bus.out_last = sel_valid && eff_last;
    bus.out_id = rst_n ? sel : '0;
    bus.req_ready = fire ? N'(1) << sel : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      beats <= '0;
    end else if (fire) begin
      state <= eff_last ? IDLE : BURST;
      ptr <= eff_last ? IW'(rr_next(int'(sel), N)) : ptr;
      owner <= sel;
      beats <= eff_last ? '0 : beats + BW'(1);
    end
  end
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// tb_burst_rr_arbiter: table-driven and scoreboard checks of burst_rr_arbiter in two configurations
module tb_burst_rr_arbiter;
  typedef struct packed {logic [7:0] a; logic b;} pl_t;
  typedef struct {logic [3:0] v, l; logic rdy; logic [1:0] id; logic [3:0] rr; logic ov, ol;} vec_t;
  typedef struct {logic [1:0] id; logic [3:0] rr; logic ov, ol; logic [31:0] d;} exp_t;
  typedef struct {logic id; pl_t d;} exp2_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t tv[$];
  exp_t sb[$];
  exp2_t sb2[$];
  always #5 clk = ~clk;
  burst_rr_arbiter_if #(.N(4)) bus ();
  burst_rr_arbiter_if #(.T(pl_t), .N(2)) bus2 ();
  burst_rr_arbiter #(.N(4), .MAX_BURST(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  burst_rr_arbiter #(.T(pl_t), .N(2), .MAX_BURST(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic vec_t row(logic [3:0] v, logic [3:0] l, logic rdy, logic [1:0] id, logic [3:0] rr, logic ov, logic ol);
    row = '{v, l, rdy, id, rr, ov, ol};
  endfunction
  task automatic apply(vec_t t, int n);
    exp_t e;
    @(negedge clk);
    bus.req_valid = t.v;
    bus.req_last = t.l;
    bus.out_ready = t.rdy;
    sb.push_back('{t.id, t.rr, t.ov, t.ol, t.ov ? 32'hA0 + 32'(t.id) : 32'h0});
    #1;
    e = sb.pop_front();
    chk($sformatf("row%0d id", n), 32'(bus.out_id), 32'(e.id));
    chk($sformatf("row%0d req_ready", n), 32'(bus.req_ready), 32'(e.rr));
    chk($sformatf("row%0d out_valid", n), 32'(bus.out_valid), 32'(e.ov));
    chk($sformatf("row%0d out_last", n), 32'(bus.out_last), 32'(e.ol));
    chk($sformatf("row%0d out_data", n), bus.out_data, e.d);
  endtask
  initial begin
    exp2_t e2;
    for (int i = 0; i < 4; i++) bus.req_data[i] = 32'hA0 + 32'(i);
    bus.req_valid = 4'hF;
    bus.req_last = 4'hF;
    bus.out_ready = 1'b1;
    bus2.req_valid = '0;
    bus2.req_last = '0;
    bus2.out_ready = 1'b0;
    bus2.req_data[0] = '0;
    bus2.req_data[1] = '0;
    #12;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset req_ready", 32'(bus.req_ready), 0);
    chk("reset out_id", 32'(bus.out_id), 0);
    chk("reset out_last", 32'(bus.out_last), 0);
    chk("reset out_data", bus.out_data, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) tv.push_back(row(4'hF, 4'hF, 1'b1, 2'(k % 4), 4'(1 << (k % 4)), 1'b1, 1'b1));
    tv.push_back(row(4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    tv.push_back(row(4'b0101, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0));
    tv.push_back(row(4'b0101, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0));
    tv.push_back(row(4'b0101, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1));
    tv.push_back(row(4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
    tv.push_back(row(4'b0000, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) tv.push_back(row(4'b1010, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, k == 3));
    tv.push_back(row(4'b1010, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0));
    for (int k = 0; k < 5; k++) tv.push_back(row(4'b1010, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) tv.push_back(row(4'b1010, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b1, k == 2));
    tv.push_back(row(4'b0100, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0));
    tv.push_back(row(4'b0001, 4'b0001, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
    tv.push_back(row(4'b0101, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0));
    foreach (tv[i]) apply(tv[i], i);
    @(posedge clk);
    #3;
    chk("pre-reset out_valid", 32'(bus.out_valid), 1);
    chk("pre-reset out_id", 32'(bus.out_id), 2);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid), 0);
    chk("async reset req_ready", 32'(bus.req_ready), 0);
    chk("async reset out_id", 32'(bus.out_id), 0);
    bus.req_valid = 4'b0110;
    bus.req_last = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset out_id", 32'(bus.out_id), 1);
    chk("post-reset req_ready", 32'(bus.req_ready), 32'b0010);
    chk("post-reset out_valid", 32'(bus.out_valid), 1);
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus2.req_valid = 2'b11;
      bus2.req_last = 2'b00;
      bus2.out_ready = 1'b1;
      bus2.req_data[0] = pl_t'(9'($urandom));
      bus2.req_data[1] = pl_t'(9'($urandom));
      sb2.push_back('{1'(k % 2), bus2.req_data[k % 2]});
      #1;
      if (bus2.out_valid && bus2.out_ready) begin
        e2 = sb2.pop_front();
        chk($sformatf("dut2 beat%0d id", k), 32'(bus2.out_id), 32'(e2.id));
        chk($sformatf("dut2 beat%0d data", k), 32'(bus2.out_data), 32'(e2.d));
        chk($sformatf("dut2 beat%0d last", k), 32'(bus2.out_last), 1);
      end else begin
        chk($sformatf("dut2 beat%0d out_valid", k), 32'(bus2.out_valid), 1);
      end
    end
    chk("dut2 scoreboard left", 32'(sb2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
